mmcm_phase_ctrl: RTL

//  Closed-loop controller for the MMCM dynamic fine phase shift port (psen/psincdec/psdone).

---
 rtl/mmcm_phase_ctrl_pkg.sv | 13 +
 rtl/mmcm_phase_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mmcm_phase_ctrl_pkg.sv
// Shared definitions for the MMCM fine phase shift controller.
package mmcm_phase_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } ps_state_e;

  // One fine step is 1/(56*Fvco).
  localparam int unsigned FINE_STEPS_PER_VCO = 56;

endpackage

// File: rtl/mmcm_phase_ctrl.sv
// Closed-loop driver for the MMCM dynamic phase shift port: steps psen/psincdec
// one fine step at a time until the (clamped) target phase is reached.
module mmcm_phase_ctrl
  import mmcm_phase_ctrl_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH    = 8,
  parameter int          PHASE_MIN      = -128,
  parameter int          PHASE_MAX      = 127,
  parameter int unsigned PSDONE_TIMEOUT = 31
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          locked,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_rel,
  input  logic signed [PHASE_WIDTH-1:0] cmd_phase,
  output logic                          psen,
  output logic                          psincdec,
  input  logic                          psdone,
  output logic signed [PHASE_WIDTH-1:0] cur_phase,
  output logic                          busy,
  output logic                          err_timeout
);

  localparam int unsigned SUM_W = PHASE_WIDTH + 1;
  localparam int unsigned TMO_W = 8;
  localparam logic signed [SUM_W-1:0] MIN_S = SUM_W'(PHASE_MIN);
  localparam logic signed [SUM_W-1:0] MAX_S = SUM_W'(PHASE_MAX);

  ps_state_e                    state_q, state_d;
  logic signed [PHASE_WIDTH-1:0] target_q, target_d;
  logic signed [PHASE_WIDTH-1:0] cur_q, cur_d;
  logic                         busy_q, busy_d;
  logic                         err_q, err_d;
  logic                         psen_q, psen_d;
  logic                         incdec_q, incdec_d;
  logic [TMO_W-1:0]             tmo_q, tmo_d;

  logic signed [SUM_W-1:0]       cur_ext, cmd_ext, sum_c;
  logic signed [PHASE_WIDTH-1:0] target_c;

  assign cmd_ready   = (state_q == ST_IDLE) && locked && !err_q;
  assign psen        = psen_q;
  assign psincdec    = incdec_q;
  assign cur_phase   = cur_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

  // Widen by one bit so a relative sum cannot wrap before clamping.
  always_comb begin : target_calc
    cur_ext = {cur_q[PHASE_WIDTH-1], cur_q};
    cmd_ext = {cmd_phase[PHASE_WIDTH-1], cmd_phase};
    sum_c   = cmd_rel ? (cur_ext + cmd_ext) : cmd_ext;
    if (sum_c < MIN_S) begin
      target_c = PHASE_WIDTH'(MIN_S);
    end else if (sum_c > MAX_S) begin
      target_c = PHASE_WIDTH'(MAX_S);
    end else begin
      target_c = PHASE_WIDTH'(sum_c);
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    target_d = target_q;
    cur_d    = cur_q;
    busy_d   = busy_q;
    err_d    = err_q;
    psen_d   = 1'b0;
    incdec_d = incdec_q;
    tmo_d    = tmo_q;
    if (!locked) begin
      // Lock loss wipes phase state, even over a coincident psdone.
      state_d  = ST_IDLE;
      target_d = '0;
      cur_d    = '0;
      busy_d   = 1'b0;
      err_d    = 1'b0;
      incdec_d = 1'b0;
      tmo_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          busy_d = 1'b0;
          if (cmd_valid && cmd_ready) begin
            target_d = target_c;
            busy_d   = 1'b1;
            if (target_c != cur_q) state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          psen_d   = 1'b1;
          incdec_d = (target_q > cur_q);
          tmo_d    = TMO_W'(PSDONE_TIMEOUT);
          state_d  = ST_WAIT;
        end
        ST_WAIT: begin
          if (psdone) begin
            cur_d = incdec_q ? (cur_q + PHASE_WIDTH'(1)) : (cur_q - PHASE_WIDTH'(1));
            if (cur_d == target_q) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
            end else begin
              state_d = ST_ISSUE;
            end
          end else begin
            tmo_d = tmo_q - TMO_W'(1);
            if (tmo_q <= TMO_W'(1)) begin
              err_d   = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      cur_q    <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      psen_q   <= 1'b0;
      incdec_q <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      cur_q    <= cur_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      psen_q   <= psen_d;
      incdec_q <= incdec_d;
      tmo_q    <= tmo_d;
    end
  end

endmodule
